// File: rtl/fully_pipelined_subtractor_pkg.sv
// rtl/fully_pipelined_subtractor_pkg.sv - bit-level borrow arithmetic shared by the subtractor cells
package fully_pipelined_subtractor_pkg;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Borrow out of x - y - bi: needed when y exceeds x, or they tie and a borrow arrives.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

endpackage

// File: rtl/fully_pipelined_subtractor_cell.sv
// rtl/fully_pipelined_subtractor_cell.sv - combinational one-bit full subtractor
module full_subtractor_cell
    import fully_pipelined_subtractor_pkg::*;
(
    input  logic i_x,
    input  logic i_y,
    input  logic i_bi,
    output logic o_d,
    output logic o_bo
);

    assign o_d  = fs_diff(i_x, i_y, i_bi);
    assign o_bo = fs_borrow(i_x, i_y, i_bi);

endmodule

// File: rtl/fully_pipelined_subtractor.sv
// rtl/fully_pipelined_subtractor.sv - skewed ripple-borrow subtractor, one borrow cell per pipeline stage
module fully_pipelined_subtractor
    import fully_pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int LATENCY = WIDTH;

    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic [WIDTH-1:0]   w_bi;
    logic [WIDTH-1:0]   w_cell_d;
    logic [WIDTH-1:0]   w_cell_bo;
    logic [WIDTH-1:0]   w_d_aligned;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   r_borrow;
    logic [LATENCY-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_diff   <= '0;
            r_borrow <= '0;
        end else begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            r_diff   <= w_cell_d;
            r_borrow <= w_cell_bo;
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        localparam int DESKEW = WIDTH - 1 - k;

        // Operand bit k waits k cycles so it meets the borrow rippling up from stage k-1.
        if (k == 0) begin : g_head
            assign w_x[k]  = a[k];
            assign w_y[k]  = b[k];
            assign w_bi[k] = bin;
        end else begin : g_skew
            logic r_a_sr [k];
            logic r_b_sr [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        r_a_sr[j] <= 1'b0;
                        r_b_sr[j] <= 1'b0;
                    end
                end else begin
                    r_a_sr[0] <= a[k];
                    r_b_sr[0] <= b[k];
                    for (int j = 1; j < k; j++) begin
                        r_a_sr[j] <= r_a_sr[j-1];
                        r_b_sr[j] <= r_b_sr[j-1];
                    end
                end
            end

            assign w_x[k]  = r_a_sr[k-1];
            assign w_y[k]  = r_b_sr[k-1];
            assign w_bi[k] = r_borrow[k-1];
        end

        full_subtractor_cell u_cell (
            .i_x  (w_x[k]),
            .i_y  (w_y[k]),
            .i_bi (w_bi[k]),
            .o_d  (w_cell_d[k]),
            .o_bo (w_cell_bo[k])
        );

        // Early bits are held back until the top bit of the same operand completes.
        if (DESKEW == 0) begin : g_direct
            assign w_d_aligned[k] = r_diff[k];
        end else begin : g_deskew
            logic r_dsk [DESKEW];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DESKEW; j++) begin
                        r_dsk[j] <= 1'b0;
                    end
                end else begin
                    r_dsk[0] <= r_diff[k];
                    for (int j = 1; j < DESKEW; j++) begin
                        r_dsk[j] <= r_dsk[j-1];
                    end
                end
            end

            assign w_d_aligned[k] = r_dsk[DESKEW-1];
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign d         = w_d_aligned;
    assign bout      = r_borrow[WIDTH-1];

endmodule
